prog_seq_fsm: RTL and testbench

Programmable, table-driven Moore sequencer. It replaces hard-wired, flattened controller FSMs of the 6-flop / 7-input / 19-output class with one parametrised block. State count, input width, output width and per-state dwell time are generics. Behaviour is loaded at run time through a configuration port, so the same netlist serves any controller that fits the table.

---
 rtl/prog_seq_fsm_pkg.sv | 60 ++++++
 rtl/prog_seq_table.sv | 57 +++++
 rtl/prog_seq_fsm.sv | 151 +++++++++++++++
 tb/tb_prog_seq_fsm.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_fsm_pkg.sv
// -----------------------------------------------------------------------------
// prog_seq_fsm_pkg
// Shared definitions for the table-driven Moore sequencer.
// Holds:
//   - the default geometry (SW_D, IW_D, OW_D, CW_D);
//   - the derived widths CSW and EW;
//   - the packed entry struct for the default geometry;
//   - constant functions that give the field offsets for any geometry.
// Entry layout, MSB to LSB: out | nxt_t | nxt_f | csel | cinv | dwell
// -----------------------------------------------------------------------------
package prog_seq_fsm_pkg;

    localparam int SW_D = 6;
    localparam int IW_D = 7;
    localparam int OW_D = 19;
    localparam int CW_D = 8;

    // csel must be able to encode every input index plus the "always true" code IW
    localparam int CSW = $clog2(IW_D + 1);
    localparam int EW  = OW_D + 2 * SW_D + CSW + 1 + CW_D;

    typedef struct packed {
        logic [OW_D-1:0] out;
        logic [SW_D-1:0] nxt_t;
        logic [SW_D-1:0] nxt_f;
        logic [CSW-1:0]  csel;
        logic            cinv;
        logic [CW_D-1:0] dwell;
    } prog_seq_entry_t;

    function automatic int csel_width(input int iw);
        return $clog2(iw + 1);
    endfunction

    function automatic int entry_width(input int sw, input int iw, input int ow, input int cw);
        return ow + 2 * sw + csel_width(iw) + 1 + cw;
    endfunction

    // dwell occupies bits [cw-1:0]; everything else stacks above it
    function automatic int cinv_lsb(input int cw);
        return cw;
    endfunction

    function automatic int csel_lsb(input int cw);
        return cw + 1;
    endfunction

    function automatic int nxtf_lsb(input int cw, input int csw);
        return cw + 1 + csw;
    endfunction

    function automatic int nxtt_lsb(input int cw, input int csw, input int sw);
        return cw + 1 + csw + sw;
    endfunction

    function automatic int out_lsb(input int cw, input int csw, input int sw);
        return cw + 1 + csw + 2 * sw;
    endfunction

endpackage

// File: rtl/prog_seq_table.sv
// -----------------------------------------------------------------------------
// prog_seq_table
// Flop-based 2^SW x EW behaviour table for prog_seq_fsm. All entries clear
// asynchronously.
// Ports:
//   CK, CLR               clock and async active-low clear
//   we, cfg_addr, wdata   single write port
//   rdata                 registered read of cfg_addr; returns pre-write data
//                         when read and write hit the same address
//   exec_addr, exec_ctrl  combinational read of the control fields
//                         (bits below OL) for the current state
//   look_addr, look_out   combinational read of the out field (OW bits at OL)
//                         for the state being entered
// -----------------------------------------------------------------------------
module prog_seq_table #(
    parameter int SW = 6,
    parameter int EW = 43,
    parameter int OL = 24,
    parameter int OW = 19
) (
    input  logic          CK,
    input  logic          CLR,
    input  logic          we,
    input  logic [SW-1:0] cfg_addr,
    input  logic [EW-1:0] wdata,
    output logic [EW-1:0] rdata,
    input  logic [SW-1:0] exec_addr,
    output logic [OL-1:0] exec_ctrl,
    input  logic [SW-1:0] look_addr,
    output logic [OW-1:0] look_out
);

    localparam int DEPTH = 2 ** SW;

    logic [EW-1:0] mem_r [DEPTH];
    logic [EW-1:0] rdata_r;

    // Table storage and config read register; the read samples the old word
    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
            rdata_r <= {EW{1'b0}};
        end else begin
            if (we) begin
                mem_r[cfg_addr] <= wdata;
            end
            rdata_r <= mem_r[cfg_addr];
        end
    end

    assign rdata     = rdata_r;
    assign exec_ctrl = mem_r[exec_addr][OL-1:0];
    assign look_out  = mem_r[look_addr][OL +: OW];

endmodule

// File: rtl/prog_seq_fsm.sv
// -----------------------------------------------------------------------------
// prog_seq_fsm
// Programmable table-driven Moore sequencer. Each table entry gives:
//   - the output word;
//   - two successor states;
//   - a condition select with inversion;
//   - a minimum dwell.
// Ports:
//   CK, CLR     clock and async active-low reset (clears the table as well)
//   run         free-running execution enable
//   step        single tick when run=0
//   cfg_we      table write strobe, honoured only while run=0
//   cfg_addr    table address for writes and config reads
//   cfg_wdata   entry write data
//   cfg_rdata   registered read of cfg_addr
//   cfg_err     sticky flag: a write was attempted while running
//   in          condition inputs
//   out         registered Moore output, always the word of the current state
//   state       current state
//   halted      current entry is absorbing (unconditional self-loop, no dwell)
// -----------------------------------------------------------------------------
module prog_seq_fsm
    import prog_seq_fsm_pkg::*;
#(
    parameter  int SW   = SW_D,
    parameter  int IW   = IW_D,
    parameter  int OW   = OW_D,
    parameter  int CW   = CW_D,
    localparam int CSWL = csel_width(IW),
    localparam int EWL  = entry_width(SW, IW, OW, CW)
) (
    input  logic           CK,
    input  logic           CLR,
    input  logic           run,
    input  logic           step,
    input  logic           cfg_we,
    input  logic [SW-1:0]  cfg_addr,
    input  logic [EWL-1:0] cfg_wdata,
    output logic [EWL-1:0] cfg_rdata,
    output logic           cfg_err,
    input  logic [IW-1:0]  in,
    output logic [OW-1:0]  out,
    output logic [SW-1:0]  state,
    output logic           halted
);

    localparam int CIL = cinv_lsb(CW);
    localparam int CSL = csel_lsb(CW);
    localparam int NFL = nxtf_lsb(CW, CSWL);
    localparam int NTL = nxtt_lsb(CW, CSWL, SW);
    localparam int OL  = out_lsb(CW, CSWL, SW);

    logic [SW-1:0]   state_r;
    logic [SW-1:0]   state_next_s;
    logic [CW-1:0]   dcnt_r;
    logic [CW-1:0]   dcnt_next_s;
    logic [OW-1:0]   out_r;
    logic            cfg_err_r;

    logic [OL-1:0]   ctrl_s;
    logic [OW-1:0]   next_out_s;
    logic [CW-1:0]   dwell_s;
    logic            cinv_s;
    logic [CSWL-1:0] csel_s;
    logic [SW-1:0]   nxt_f_s;
    logic [SW-1:0]   nxt_t_s;
    logic            tick_s;
    logic            cond_s;
    logic            always_true_s;
    logic            wr_en_s;

    // Writes are only legal while stopped, so execution never sees a half-changed entry
    assign wr_en_s = cfg_we & ~run;
    assign tick_s  = run | step;

    prog_seq_table #(
        .SW (SW),
        .EW (EWL),
        .OL (OL),
        .OW (OW)
    ) u_table (
        .CK        (CK),
        .CLR       (CLR),
        .we        (wr_en_s),
        .cfg_addr  (cfg_addr),
        .wdata     (cfg_wdata),
        .rdata     (cfg_rdata),
        .exec_addr (state_r),
        .exec_ctrl (ctrl_s),
        .look_addr (state_next_s),
        .look_out  (next_out_s)
    );

    assign dwell_s = ctrl_s[CW-1:0];
    assign cinv_s  = ctrl_s[CIL];
    assign csel_s  = ctrl_s[CSL +: CSWL];
    assign nxt_f_s = ctrl_s[NFL +: SW];
    assign nxt_t_s = ctrl_s[NTL +: SW];

    // csel codes at or above IW all mean "unconditionally true"
    assign always_true_s = (csel_s >= CSWL'(IW));

    // Condition evaluation from the current entry
    always_comb begin
        cond_s = 1'b1;
        if (always_true_s) begin
            cond_s = 1'b1;
        end else begin
            cond_s = in[csel_s] ^ cinv_s;
        end
    end

    // Dwell count and successor selection; every transition restarts the dwell
    always_comb begin
        state_next_s = state_r;
        dcnt_next_s  = dcnt_r;
        if (tick_s) begin
            if (dcnt_r < dwell_s) begin
                dcnt_next_s = dcnt_r + 1'b1;
            end else begin
                dcnt_next_s  = {CW{1'b0}};
                state_next_s = cond_s ? nxt_t_s : nxt_f_s;
            end
        end else begin
            state_next_s = state_r;
            dcnt_next_s  = dcnt_r;
        end
    end

    // Sequencer state, dwell counter, output word and sticky config error
    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            state_r   <= {SW{1'b0}};
            dcnt_r    <= {CW{1'b0}};
            out_r     <= {OW{1'b0}};
            cfg_err_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            dcnt_r    <= dcnt_next_s;
            // reloaded every cycle so an edited entry shows up one cycle after its write
            out_r     <= next_out_s;
            cfg_err_r <= cfg_err_r | (cfg_we & run);
        end
    end

    assign state   = state_r;
    assign out     = out_r;
    assign cfg_err = cfg_err_r;
    assign halted  = always_true_s && (nxt_t_s == state_r) && (dwell_s == {CW{1'b0}});

endmodule

// File: tb/tb_prog_seq_fsm.sv
module tb_prog_seq_fsm;
    import prog_seq_fsm_pkg::*;

    logic          ck = 1'b0;
    logic          clr;
    logic          run;
    logic          step;
    logic          cfg_we;
    logic [5:0]    cfg_addr;
    logic [EW-1:0] cfg_wdata;
    logic [EW-1:0] cfg_rdata_w;
    logic          cfg_err_w;
    logic [6:0]    cond_in;
    logic [18:0]   out_w;
    logic [5:0]    state_w;
    logic          halted_w;

    int checks = 0;
    int errors = 0;

    // Reference model: table contents, current state, ticks spent in it so far
    prog_seq_entry_t tbl [64];
    int              m_state;
    int              m_ticks;
    logic [18:0]     m_out;
    logic [EW-1:0]   m_rdata;
    bit              m_err;

    always #5 ck = ~ck;

    prog_seq_fsm dut (
        .CK        (ck),
        .CLR       (clr),
        .run       (run),
        .step      (step),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata_w),
        .cfg_err   (cfg_err_w),
        .in        (cond_in),
        .out       (out_w),
        .state     (state_w),
        .halted    (halted_w)
    );

    function automatic prog_seq_entry_t mk(input logic [18:0] o, input logic [5:0] nt,
                                           input logic [5:0] nf, input logic [2:0] cs,
                                           input logic ci, input logic [7:0] dw);
        prog_seq_entry_t e;
        e.out = o; e.nxt_t = nt; e.nxt_f = nf; e.csel = cs; e.cinv = ci; e.dwell = dw;
        return e;
    endfunction

    function automatic prog_seq_entry_t rand_entry();
        return mk(19'($urandom), 6'($urandom), 6'($urandom), 3'($urandom),
                  1'($urandom), 8'($urandom_range(3, 0)));
    endfunction

    function automatic bit entry_cond(input prog_seq_entry_t e, input logic [6:0] c);
        if (int'(e.csel) >= 7) return 1'b1;
        return c[e.csel] ^ e.cinv;
    endfunction

    function automatic bit model_halted();
        prog_seq_entry_t e;
        e = tbl[m_state];
        return (int'(e.csel) >= 7) && (int'(e.nxt_t) == m_state) && (e.dwell == 8'd0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state",     64'(state_w),     64'(m_state));
        chk("out",       64'(out_w),       64'(m_out));
        chk("halted",    64'(halted_w),    64'(model_halted()));
        chk("cfg_err",   64'(cfg_err_w),   64'(m_err));
        chk("cfg_rdata", 64'(cfg_rdata_w), 64'(m_rdata));
        chk("dcnt",      64'(dut.dcnt_r),  64'(m_ticks));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) tbl[i] = '0;
        m_state = 0; m_ticks = 0; m_out = '0; m_rdata = '0; m_err = 1'b0;
    endtask

    // One clock: predict from the pre-edge table and inputs, clock, then compare
    task automatic cycle();
        prog_seq_entry_t e;
        int              n_state;
        int              n_ticks;
        logic [18:0]     n_out;
        logic [EW-1:0]   n_rdata;
        e       = tbl[m_state];
        n_state = m_state;
        n_ticks = m_ticks;
        if (run || step) begin
            if (m_ticks < int'(e.dwell)) n_ticks = m_ticks + 1;
            else begin
                n_ticks = 0;
                n_state = entry_cond(e, cond_in) ? int'(e.nxt_t) : int'(e.nxt_f);
            end
        end
        n_out   = tbl[n_state].out;
        n_rdata = tbl[cfg_addr];
        if (cfg_we && run) m_err = 1'b1;
        if (cfg_we && !run) tbl[cfg_addr] = prog_seq_entry_t'(cfg_wdata);
        @(posedge ck);
        m_state = n_state; m_ticks = n_ticks; m_out = n_out; m_rdata = n_rdata;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        clr = 1'b0;
        #2;
        model_clear();
        check_all();
        @(posedge ck);
        #1;
        clr = 1'b1;
    endtask

    task automatic wr(input logic [5:0] a, input prog_seq_entry_t e);
        run = 1'b0; step = 1'b0; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = e;
        cycle();
        cfg_we = 1'b0;
    endtask

    initial begin
        int exp_seq [8];
        exp_seq = '{1, 1, 1, 0, 1, 1, 1, 0};
        clr = 1'b0; run = 1'b0; step = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; cond_in = '0;
        model_clear();
        do_reset();

        // Two-state toggle
        wr(6'd0, mk(19'h00001, 6'd1, 6'd0, 3'd7, 1'b0, 8'd0));
        wr(6'd1, mk(19'h40000, 6'd0, 6'd0, 3'd7, 1'b0, 8'd2));
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("toggle_state", 64'(state_w), 64'(exp_seq[i]));
            chk("toggle_out", 64'(out_w), (exp_seq[i] == 0) ? 64'h00001 : 64'h40000);
        end
        run = 1'b0;

        // Conditional branch, both polarities of in[3]
        do_reset();
        wr(6'd0, mk(19'h00011, 6'd2, 6'd4, 3'd3, 1'b1, 8'd0));
        cond_in = 7'h00; step = 1'b1; cycle(); step = 1'b0;
        chk("branch_in3_0", 64'(state_w), 64'd2);
        do_reset();
        wr(6'd0, mk(19'h00011, 6'd2, 6'd4, 3'd3, 1'b1, 8'd0));
        cond_in = 7'h08; step = 1'b1; cycle(); step = 1'b0;
        chk("branch_in3_1", 64'(state_w), 64'd4);

        // Step mode on a dwell=1 state
        do_reset();
        cond_in = 7'h00;
        wr(6'd0, mk(19'h00005, 6'd1, 6'd1, 3'd7, 1'b0, 8'd1));
        wr(6'd1, mk(19'h00006, 6'd0, 6'd0, 3'd7, 1'b0, 8'd2));
        step = 1'b1; cycle(); step = 1'b0;
        chk("step1_dcnt", 64'(dut.dcnt_r), 64'd1);
        cycle(); cycle();
        chk("step_idle_state", 64'(state_w), 64'd0);
        step = 1'b1; cycle(); step = 1'b0;
        chk("step2_state", 64'(state_w), 64'd1);
        cycle();
        step = 1'b1; cycle(); step = 1'b0;
        chk("step3_dcnt", 64'(dut.dcnt_r), 64'd1);
        run = 1'b1; step = 1'b1; cycle(); cycle(); run = 1'b0; step = 1'b0;
        chk("run_ignores_step", 64'(state_w), 64'd0);

        // Config guard and same-cycle read/write
        do_reset();
        wr(6'd9, mk(19'h0AAAA, 6'd3, 6'd4, 3'd2, 1'b0, 8'd5));
        run = 1'b1; cfg_we = 1'b1; cfg_addr = 6'd9;
        cfg_wdata = mk(19'h05555, 6'd1, 6'd1, 3'd1, 1'b1, 8'd1);
        cycle();
        cfg_we = 1'b0; run = 1'b0;
        chk("guard_err", 64'(cfg_err_w), 64'd1);
        cycle();
        chk("guard_readback", 64'(cfg_rdata_w),
            64'(mk(19'h0AAAA, 6'd3, 6'd4, 3'd2, 1'b0, 8'd5)));
        wr(6'd9, mk(19'h12345, 6'd7, 6'd8, 3'd6, 1'b1, 8'd9));
        chk("rw_same_old", 64'(cfg_rdata_w),
            64'(mk(19'h0AAAA, 6'd3, 6'd4, 3'd2, 1'b0, 8'd5)));
        cfg_addr = 6'd9; cycle();
        chk("rw_same_new", 64'(cfg_rdata_w),
            64'(mk(19'h12345, 6'd7, 6'd8, 3'd6, 1'b1, 8'd9)));
        chk("err_sticky", 64'(cfg_err_w), 64'd1);

        // Halt and self-transition with dwell
        wr(6'd0, mk(19'h00003, 6'd7, 6'd7, 3'd7, 1'b0, 8'd0));
        wr(6'd7, mk(19'h00070, 6'd7, 6'd7, 3'd7, 1'b0, 8'd0));
        run = 1'b1; cycle(); cycle(); run = 1'b0;
        chk("halt_state", 64'(state_w), 64'd7);
        chk("halt_flag", 64'(halted_w), 64'd1);
        wr(6'd7, mk(19'h00070, 6'd7, 6'd7, 3'd7, 1'b0, 8'd3));
        chk("unhalt_flag", 64'(halted_w), 64'd0);
        run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cycle();
            chk("self_dcnt", 64'(dut.dcnt_r), 64'((i + 1) % 4));
        end
        run = 1'b0;

        // Reset aborting a run at state 5
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wr(6'(i), mk(19'(i + 16), 6'(i + 1), 6'(i + 1), 3'd7, 1'b0, 8'd0));
        end
        run = 1'b1; cfg_we = 1'b1; cfg_addr = 6'd40; cfg_wdata = '1;
        cycle();
        cfg_we = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("pre_reset_state", 64'(state_w), 64'd5);
        do_reset();
        chk("post_reset_err", 64'(cfg_err_w), 64'd0);
        run = 1'b0; cfg_addr = 6'd3; cycle();
        chk("post_reset_read", 64'(cfg_rdata_w), 64'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 64; i++) wr(6'(i), rand_entry());
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            run       = ($urandom_range(3, 0) != 0);
            step      = 1'($urandom);
            cond_in   = 7'($urandom);
            cfg_we    = ($urandom_range(5, 0) == 0);
            cfg_addr  = 6'($urandom);
            cfg_wdata = rand_entry();
            cycle();
        end
        cfg_we = 1'b0; run = 1'b0; step = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
